// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC gateway: per-source state encoding,
// the reserved source id and the id legality check.
package plic_pkg;

  // The pending/claimed bits are the state bits themselves, so the
  // register-readable pending and inflight outputs come straight off flops.
  typedef enum logic [1:0] {
    GW_IDLE    = 2'b00,
    GW_PENDING = 2'b01,
    GW_CLAIMED = 2'b10
  } plic_gw_state_e;

  localparam int unsigned PLIC_RESERVED_ID = 0;

  function automatic logic plic_id_ok(input logic [31:0] id, input int unsigned num_sources);
    return (id != PLIC_RESERVED_ID) && (id < num_sources);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: synchroniser, registered rising-edge detect,
// IDLE/PENDING/CLAIMED gateway FSM and the one-deep edge_seen flag.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           irq,
  input  logic           edge_mode,
  input  logic           claim,
  input  logic           complete,
  output plic_gw_state_e state,
  output logic           pending,
  output logic           inflight
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   rise_q;
  logic                   seen_q;
  plic_gw_state_e         state_q;

  logic s;
  logic trig;
  logic edge_ev;

  assign s       = sync_q[SYNC_STAGES-1];
  // The edge is registered, which is why edge mode has one more cycle of latency.
  assign edge_ev = edge_mode & rise_q;
  assign trig    = edge_mode ? rise_q : s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      seen_q  <= 1'b0;
      state_q <= GW_IDLE;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d_q  <= s;
      rise_q <= s & ~s_d_q;

      case (state_q)
        GW_IDLE: begin
          if (trig) state_q <= GW_PENDING;
        end
        GW_PENDING: begin
          if (claim) begin
            state_q <= GW_CLAIMED;
            seen_q  <= edge_ev;
          end
        end
        GW_CLAIMED: begin
          if (complete) begin
            state_q <= (seen_q | edge_ev | (~edge_mode & s)) ? GW_PENDING : GW_IDLE;
            seen_q  <= 1'b0;
          end else if (edge_ev) begin
            seen_q <= 1'b1;
          end
        end
        default: state_q <= GW_IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign pending  = state_q[0];
  assign inflight = state_q[1];

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway array: one cell per source 1..N-1, claim/complete id decode
// and the one-cycle error pulses. Source 0 is reserved and always idle.
module plic_gateway
  import plic_pkg::*;
#(
  parameter  int PLIC_NUM_SOURCES = 32,
  parameter  int SYNC_STAGES      = 2,
  localparam int ID_W             = $clog2(PLIC_NUM_SOURCES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PLIC_NUM_SOURCES-1:0] irq_src_i,
  input  logic [PLIC_NUM_SOURCES-1:0] src_edge_mode_i,
  input  logic [PLIC_NUM_SOURCES-1:0] src_enable_i,
  input  logic                        claim_i,
  input  logic [ID_W-1:0]             claim_id_i,
  input  logic                        complete_i,
  input  logic [ID_W-1:0]             complete_id_i,
  output logic [PLIC_NUM_SOURCES-1:0] pending_o,
  output logic [PLIC_NUM_SOURCES-1:0] valid_o,
  output logic [PLIC_NUM_SOURCES-1:0] inflight_o,
  output logic                        claim_err_o,
  output logic                        complete_err_o
);

  plic_gw_state_e              gw_state [PLIC_NUM_SOURCES];
  logic [PLIC_NUM_SOURCES-1:0] pending;
  logic [PLIC_NUM_SOURCES-1:0] inflight;
  logic                        claim_ok;
  logic                        complete_ok;
  logic                        claim_err_q;
  logic                        complete_err_q;
  logic                        unused_src0;

  // claim_i/complete_i are single-cycle strobes with no back-pressure: each
  // strobe is consumed in the cycle it is presented, either acted on by the
  // addressed cell or answered by an error pulse on the following cycle.
  assign claim_ok    = claim_i && plic_id_ok(32'(claim_id_i), PLIC_NUM_SOURCES)
                       && (gw_state[claim_id_i] == GW_PENDING);
  assign complete_ok = complete_i && plic_id_ok(32'(complete_id_i), PLIC_NUM_SOURCES)
                       && (gw_state[complete_id_i] == GW_CLAIMED);

  assign gw_state[0] = GW_IDLE;
  assign pending[0]  = 1'b0;
  assign inflight[0] = 1'b0;
  assign unused_src0 = irq_src_i[0] ^ src_edge_mode_i[0];

  for (genvar k = 1; k < PLIC_NUM_SOURCES; k++) begin : g_cell
    plic_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .irq       (irq_src_i[k]),
      .edge_mode (src_edge_mode_i[k]),
      .claim     (claim_ok && (claim_id_i == ID_W'(k))),
      .complete  (complete_ok && (complete_id_i == ID_W'(k))),
      .state     (gw_state[k]),
      .pending   (pending[k]),
      .inflight  (inflight[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      claim_err_q    <= 1'b0;
      complete_err_q <= 1'b0;
    end else begin
      claim_err_q    <= claim_i & ~claim_ok;
      complete_err_q <= complete_i & ~complete_ok;
    end
  end

  assign pending_o      = pending;
  assign inflight_o     = inflight;
  assign valid_o        = pending & src_enable_i;
  assign claim_err_o    = claim_err_q;
  assign complete_err_o = complete_err_q;

endmodule
